unary_mvm_engine: RTL and testbench
===================================

# unary_mvm_engine

Signed matrix–vector multiply engine: `y = A·x`, with `A` a ROWS×COLS matrix and `x` a COLS-element vector. Each `x` element is converted to a temporal-unary pulse train, and each pulse gates the weights into per-row accumulators. This is the parametrised successor to the fixed-schedule systolic unary matmul. It adds:

- a valid/ready handshake on input and output;
- arbitrary ROWS/COLS/W;
- an optional early-exit mode that ends streaming once the largest |x| has been exhausted.

It sits between the operand buffers and the result FIFO of the unary compute path.

## Interface
Parameters:
- W, 5: two's-complement width of every A and x element.
- ROWS, 2: rows of A, and number of outputs.
- COLS, 2: columns of A, and length of x.
- EARLY_EXIT, 1: 1 = stream only max|x_j| cycles; 0 = always stream T = 2^(W-1) cycles.
- ACC_W, 2*W+$clog2(COLS): signed width of each result.

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  engine accepts operands.
- a_mat  in  ROWS*COLS*W  element (i,j) at bits [(i*COLS+j)*W +: W].
- x_vec  in  COLS*W  element j at bits [j*W +: W].
- out_valid  out  1  y_vec valid.
- out_ready  in  1  consumer takes result.
- y_vec  out  ROWS*ACC_W  signed y_i at bits [i*ACC_W +: ACC_W].
- cycles_used  out  W  number of streaming cycles used for this result, 1..2^(W-1).

## Operation
- **States:** IDLE, STREAM, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&in_ready: register a_mat and x_vec.
  - Compute mag_j = |x_j| as W-bit unsigned, so -2^(W-1) gives 2^(W-1); sgn_j = x_j[W-1].
  - Clear accumulators and unary counter t; go to STREAM.
- **STREAM:**
  - Each cycle, pulse_j = (t < mag_j).
  - acc_i += Σ_j pulse_j ? (sgn_j ? -A_ij : A_ij) : 0.
  - Negation and summation are done in ACC_W-bit signed arithmetic; A is sign-extended before negation.
  - t increments every cycle.
- **Stream length L:**
  - EARLY_EXIT=0: L = 2^(W-1).
  - EARLY_EXIT=1: L = max(1, max_j mag_j).
  - When t == L-1, the update is applied and the state goes to DONE.
- **DONE:**
  - out_valid=1; y_vec = acc; cycles_used = L.
  - Outputs hold stable while out_ready=0.
  - On out_ready: go to IDLE.
  - y_vec and cycles_used keep their values until the next accept.
- **in_ready:** 0 in STREAM and DONE; in_valid there is ignored and the operands are not captured.
- **Width guarantee:** ACC_W holds every result, including the worst case COLS·2^(2W-2). There is no saturation and no wrap.
- **Reset:** reset_n low at any time, including mid-STREAM or in DONE, forces:
  - state IDLE, in_ready=1 after release;
  - out_valid=0;
  - y_vec=0, cycles_used=0;
  - accumulators and t cleared;
  - the in-flight operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, y_vec=0, cycles_used=0.
- Accept at edge E0. STREAM updates occur at edges E1..EL. out_valid rises after EL, so latency from accept to out_valid is L cycles.
- Result hand-off at edge Ek (out_valid&out_ready): in_ready is high in the cycle after Ek, so the earliest next accept is edge Ek+1.
- Minimum period per operation: L+2 cycles.
- in_ready is a registered state decode. It has no combinational path from out_ready or in_valid.
- out_valid, y_vec and cycles_used are registered.

## Test plan
- **Mixed signs, early exit.** W=5, ROWS=COLS=2, EARLY_EXIT=1; A=[[3,-2],[-16,15]], x=[4,-5] -> y=[22,-139], cycles_used=5, out_valid 5 cycles after accept.
- **Same operands, no early exit.** EARLY_EXIT=0 -> y=[22,-139], cycles_used=16, latency 16.
- **Extremes.** A all -16, x all -16 -> y=[512,512]. A all 15, x=[-16,-16] -> y=[-480,-480]. No wrap with ACC_W=11.
- **Zero vector.** x=[0,0], EARLY_EXIT=1 -> y=[0,0], cycles_used=1.
- **Backpressure.** Hold out_ready=0 for 10 cycles in DONE and toggle in_valid with new operands -> y_vec stable, in_ready=0, nothing captured. After out_ready, the next accept yields the new result.
- **Reset mid-operation.** Assert reset_n low at t=3 of a stream -> out_valid=0, y_vec=0, in_ready=1 after release. A fresh operation then produces the correct result with no residue.

Source files
------------

// File: rtl/unary_mvm_engine.sv
// unary_mvm_engine: signed y = A*x by gating weights with temporal-unary pulse trains of |x_j|
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a_mat (i,j) at [(i*COLS+j)*W +: W], x_vec j at [j*W +: W]
//   out_valid/out_ready   result handshake; y_vec row i at [i*ACC_W +: ACC_W]
//   cycles_used           stream length L of the current result
module unary_mvm_engine #(
   parameter int W          = 5,
   parameter int ROWS       = 2,
   parameter int COLS       = 2,
   parameter int EARLY_EXIT = 1,
   parameter int ACC_W      = 2*W+$clog2(COLS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ROWS*COLS*W-1:0] a_mat,
   input  logic [COLS*W-1:0]     x_vec,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ROWS*ACC_W-1:0] y_vec,
   output logic [W-1:0]          cycles_used
);
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   state_t state_q, state_d;
   logic [ROWS*COLS*W-1:0] a_q, a_d;
   logic [COLS*W-1:0] mag_q, mag_d, mag_in;
   logic [COLS-1:0] sgn_q, sgn_d, sgn_in;
   logic [W-1:0] t_q, t_d, len_q, len_d, max_mag, xs, mv;
   logic [ROWS*ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] s, ae;
   always_comb begin
      state_d = state_q;
      a_d = a_q;
      mag_d = mag_q;
      sgn_d = sgn_q;
      t_d = t_q;
      len_d = len_q;
      acc_d = acc_q;
      mag_in = '0;
      sgn_in = '0;
      max_mag = '0;
      xs = '0;
      mv = '0;
      s = '0;
      ae = '0;
      // W-bit unsigned magnitude, so the most negative value maps to 2^(W-1)
      for (int j = 0; j < COLS; j++) begin
         xs = x_vec[j*W +: W];
         mv = xs[W-1] ? ~xs + W'(1) : xs;
         mag_in[j*W +: W] = mv;
         sgn_in[j] = xs[W-1];
         max_mag = (mv > max_mag) ? mv : max_mag;
      end
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = STREAM;
            a_d = a_mat;
            mag_d = mag_in;
            sgn_d = sgn_in;
            t_d = '0;
            acc_d = '0;
            len_d = (EARLY_EXIT != 0) ? ((max_mag == '0) ? W'(1) : max_mag) : {1'b1, {(W-1){1'b0}}};
         end
         STREAM: begin
            for (int i = 0; i < ROWS; i++) begin
               s = acc_q[i*ACC_W +: ACC_W];
               for (int j = 0; j < COLS; j++) begin
                  ae = {{(ACC_W-W){a_q[(i*COLS+j)*W+W-1]}}, a_q[(i*COLS+j)*W +: W]};
                  if (t_q < mag_q[j*W +: W]) s = sgn_q[j] ? s - ae : s + ae;
               end
               acc_d[i*ACC_W +: ACC_W] = s;
            end
            t_d = t_q + W'(1);
            state_d = (t_q == len_q - W'(1)) ? DONE : STREAM;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q <= '0;
         mag_q <= '0;
         sgn_q <= '0;
         t_q <= '0;
         len_q <= '0;
         acc_q <= '0;
      end else begin
         state_q <= state_d;
         a_q <= a_d;
         mag_q <= mag_d;
         sgn_q <= sgn_d;
         t_q <= t_d;
         len_q <= len_d;
         acc_q <= acc_d;
      end
   end
   // outputs decode flops directly; the accumulators double as the result register
   assign in_ready = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign y_vec = acc_q;
   assign cycles_used = len_q;
endmodule

// File: tb/tb_unary_mvm_engine.sv
// tb_unary_mvm_engine: randomized and directed checks of both stream modes against an arithmetic model
module tb_unary_mvm_engine;
   localparam int W = 5, R = 2, C = 2, AW = 2*W+1;
   logic clk = 0, reset_n = 0;
   logic in_valid[2], in_ready[2], out_valid[2], out_ready[2];
   logic [R*C*W-1:0] a_mat[2];
   logic [C*W-1:0] x_vec[2];
   logic [R*AW-1:0] y_vec[2];
   logic [W-1:0] cycles_used[2];
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   unary_mvm_engine #(.W(W), .ROWS(R), .COLS(C), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a_mat(a_mat[0]), .x_vec(x_vec[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .y_vec(y_vec[0]), .cycles_used(cycles_used[0]));
   unary_mvm_engine #(.W(W), .ROWS(R), .COLS(C), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a_mat(a_mat[1]), .x_vec(x_vec[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .y_vec(y_vec[1]), .cycles_used(cycles_used[1]));
   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask
   function automatic int ref_y(input logic [R*C*W-1:0] a, input logic [C*W-1:0] x, input int i);
      int acc = 0;
      for (int j = 0; j < C; j++) acc += int'($signed(a[(i*C+j)*W +: W])) * int'($signed(x[j*W +: W]));
      return acc;
   endfunction
   function automatic int ref_l(input int k, input logic [C*W-1:0] x);
      int m = 1, v;
      if (k == 0) return 1 << (W-1);
      for (int j = 0; j < C; j++) begin
         v = int'($signed(x[j*W +: W]));
         v = (v < 0) ? -v : v;
         m = (v > m) ? v : m;
      end
      return m;
   endfunction
   function automatic int ys(input int k, input int i);
      logic [AW-1:0] v;
      v = y_vec[k][i*AW +: AW];
      return int'($signed(v));
   endfunction
   function automatic logic [R*C*W-1:0] pk(input int e0, input int e1, input int e2, input int e3);
      return {e3[W-1:0], e2[W-1:0], e1[W-1:0], e0[W-1:0]};
   endfunction
   function automatic logic [C*W-1:0] px(input int x0, input int x1);
      return {x1[W-1:0], x0[W-1:0]};
   endfunction
   task automatic op(input int k, input logic [R*C*W-1:0] a, input logic [C*W-1:0] x, input int hold, input string tag);
      int lat, l;
      l = ref_l(k, x);
      lat = 0;
      while (!in_ready[k] && lat < 50) begin @(posedge clk); #1; lat++; end
      chk({tag, "_rdy"}, int'(in_ready[k]), 1);
      a_mat[k] = a;
      x_vec[k] = x;
      in_valid[k] = 1;
      @(posedge clk); #1;
      in_valid[k] = 0;
      lat = 0;
      while (!out_valid[k] && lat < 40) begin @(posedge clk); #1; lat++; end
      chk({tag, "_lat"}, lat, l);
      chk({tag, "_y0"}, ys(k, 0), ref_y(a, x, 0));
      chk({tag, "_y1"}, ys(k, 1), ref_y(a, x, 1));
      chk({tag, "_cyc"}, int'(cycles_used[k]), l);
      for (int h = 0; h < hold; h++) begin
         in_valid[k] = h[0];
         a_mat[k] = 20'($urandom);
         x_vec[k] = 10'($urandom);
         @(posedge clk); #1;
         chk({tag, "_hold_y0"}, ys(k, 0), ref_y(a, x, 0));
         chk({tag, "_hold_y1"}, ys(k, 1), ref_y(a, x, 1));
         chk({tag, "_hold_rdy"}, int'(in_ready[k]), 0);
         chk({tag, "_hold_ov"}, int'(out_valid[k]), 1);
      end
      in_valid[k] = 0;
      out_ready[k] = 1;
      @(posedge clk); #1;
      out_ready[k] = 0;
      chk({tag, "_post_rdy"}, int'(in_ready[k]), 1);
      chk({tag, "_post_ov"}, int'(out_valid[k]), 0);
   endtask
   initial begin
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 0;
         out_ready[k] = 0;
         a_mat[k] = '0;
         x_vec[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_rdy", int'(in_ready[k]), 1);
         chk("rst_ov", int'(out_valid[k]), 0);
         chk("rst_y", int'(y_vec[k]), 0);
         chk("rst_cyc", int'(cycles_used[k]), 0);
      end
      op(1, pk(3, -2, -16, 15), px(4, -5), 0, "mixed_ee");
      op(0, pk(3, -2, -16, 15), px(4, -5), 0, "mixed_full");
      op(1, pk(-16, -16, -16, -16), px(-16, -16), 0, "ext_neg");
      op(1, pk(15, 15, 15, 15), px(-16, -16), 0, "ext_pos");
      op(0, pk(-16, -16, -16, -16), px(-16, -16), 0, "ext_neg_full");
      op(1, pk(7, -9, 11, -3), px(0, 0), 0, "zero_x");
      op(1, pk(5, 6, -7, 8), px(-3, 9), 10, "bp");
      op(1, pk(-1, 2, 13, -14), px(6, 2), 0, "after_bp");
      a_mat[1] = pk(9, 9, -9, 9);
      x_vec[1] = px(-16, 7);
      in_valid[1] = 1;
      @(posedge clk); #1;
      in_valid[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 0;
      #2;
      chk("midrst_ov", int'(out_valid[1]), 0);
      chk("midrst_y", int'(y_vec[1]), 0);
      chk("midrst_cyc", int'(cycles_used[1]), 0);
      @(posedge clk); #1;
      reset_n = 1;
      chk("midrst_rdy", int'(in_ready[1]), 1);
      op(1, pk(4, -3, 2, 1), px(3, -2), 0, "fresh");
      for (int n = 0; n < 25; n++)
         for (int k = 0; k < 2; k++)
            op(k, 20'($urandom), 10'($urandom), int'($urandom_range(0, 2)), "rand");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
